// File: rtl/dualport_sram_pkg.sv
// rtl/dualport_sram_pkg.sv - shared types, default map constants and byte-strobe merge helper
package dualport_sram_pkg;

    typedef enum logic [1:0] {
        REGION_MEM  = 2'd0,
        REGION_CTRL = 2'd1,
        REGION_NONE = 2'd2
    } region_t;

    localparam int SRAM_BASE  = 206800;
    localparam int SRAM_DEPTH = 1200;
    localparam int CTRL_BASE  = 411698;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W = 256;

    function automatic logic [MERGE_W-1:0] strb_merge(
        input logic [MERGE_W-1:0]   old_word,
        input logic [MERGE_W-1:0]   new_word,
        input logic [MERGE_W/8-1:0] strb
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_W / 8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dualport_sram_if.sv
// rtl/dualport_sram_if.sv - two-port word bus plus exported control bank
interface dualport_sram_if #(
    parameter int WIDTH = 32,
    parameter int NCTRL = 2
);
    logic [WIDTH-1:0]       address1, address2;
    logic [WIDTH-1:0]       wdata1, wdata2;
    logic [WIDTH/8-1:0]     wstrb1, wstrb2;
    logic                   enw1, enw2;
    logic                   enr1, enr2;
    logic [WIDTH-1:0]       rdata1, rdata2;
    logic                   rvalid1, rvalid2;
    logic                   err1, err2;
    logic                   collision;
    logic [NCTRL*WIDTH-1:0] ctrl_out;

    modport master (
        output address1, address2, wdata1, wdata2, wstrb1, wstrb2,
        output enw1, enw2, enr1, enr2,
        input  rdata1, rdata2, rvalid1, rvalid2, err1, err2, collision, ctrl_out
    );

    modport slave (
        input  address1, address2, wdata1, wdata2, wstrb1, wstrb2,
        input  enw1, enw2, enr1, enr2,
        output rdata1, rdata2, rvalid1, rvalid2, err1, err2, collision, ctrl_out
    );
endinterface

// File: rtl/dualport_sram_addr_decode.sv
// rtl/dualport_sram_addr_decode.sv - non-wrapping word-address decode into MEM/CTRL/NONE
module sram_addr_decode #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = dualport_sram_pkg::SRAM_DEPTH,
    parameter int BASE      = dualport_sram_pkg::SRAM_BASE,
    parameter int CTRL_BASE = dualport_sram_pkg::CTRL_BASE,
    parameter int NCTRL     = 2,
    parameter int MIDX_W    = 11,
    parameter int CIDX_W    = 1
) (
    input  logic [WIDTH-1:0]            addr,
    output dualport_sram_pkg::region_t  region,
    output logic [MIDX_W-1:0]           mem_index,
    output logic [CIDX_W-1:0]           ctrl_index
);
    import dualport_sram_pkg::*;

    // One extra bit keeps the upper bounds and the subtraction from wrapping.
    localparam logic [WIDTH:0] MEM_LO  = (WIDTH+1)'(longint'(BASE));
    localparam logic [WIDTH:0] MEM_HI  = (WIDTH+1)'(longint'(BASE) + longint'(DEPTH));
    localparam logic [WIDTH:0] CTRL_LO = (WIDTH+1)'(longint'(CTRL_BASE));
    localparam logic [WIDTH:0] CTRL_HI = (WIDTH+1)'(longint'(CTRL_BASE) + longint'(NCTRL));

    logic [WIDTH:0] addr_x;
    logic           in_mem, in_ctrl;

    assign addr_x  = {1'b0, addr};
    assign in_mem  = (addr_x >= MEM_LO)  && (addr_x < MEM_HI);
    assign in_ctrl = (addr_x >= CTRL_LO) && (addr_x < CTRL_HI);

    always_comb begin
        region     = REGION_NONE;
        mem_index  = '0;
        ctrl_index = '0;
        if (in_mem) begin
            region    = REGION_MEM;
            mem_index = MIDX_W'(addr_x - MEM_LO);
        end else if (in_ctrl) begin
            region     = REGION_CTRL;
            ctrl_index = CIDX_W'(addr_x - CTRL_LO);
        end
    end

endmodule

// File: rtl/dualport_sram.sv
// rtl/dualport_sram.sv - single-clock dual-port SRAM with strobed writes and a control register bank
module dualport_sram #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = dualport_sram_pkg::SRAM_DEPTH,
    parameter int BASE      = dualport_sram_pkg::SRAM_BASE,
    parameter int CTRL_BASE = dualport_sram_pkg::CTRL_BASE,
    parameter int NCTRL     = 2
) (
    input  logic            clk,
    input  logic            nrst,
    dualport_sram_if.slave  bus
);
    import dualport_sram_pkg::*;

    localparam int NB     = WIDTH / 8;
    localparam int MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CIDX_W = (NCTRL > 1) ? $clog2(NCTRL) : 1;

    region_t           region1, region2;
    logic [MIDX_W-1:0] midx1, midx2;
    logic [CIDX_W-1:0] cidx1, cidx2;

    sram_addr_decode #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .CTRL_BASE(CTRL_BASE),
        .NCTRL(NCTRL), .MIDX_W(MIDX_W), .CIDX_W(CIDX_W)
    ) u_decode1 (
        .addr(bus.address1), .region(region1), .mem_index(midx1), .ctrl_index(cidx1)
    );

    sram_addr_decode #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .CTRL_BASE(CTRL_BASE),
        .NCTRL(NCTRL), .MIDX_W(MIDX_W), .CIDX_W(CIDX_W)
    ) u_decode2 (
        .addr(bus.address2), .region(region2), .mem_index(midx2), .ctrl_index(cidx2)
    );

    function automatic logic [WIDTH-1:0] merge_w(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [NB-1:0]    strb
    );
        return WIDTH'(strb_merge(MERGE_W'(old_word), MERGE_W'(new_word), (MERGE_W/8)'(strb)));
    endfunction

    logic [WIDTH-1:0] mem    [DEPTH];
    logic [WIDTH-1:0] ctrl_q [NCTRL];
    logic [WIDTH-1:0] ctrl_d [NCTRL];
    logic [WIDTH-1:0] rd1, rd2;
    logic             wr1_mem, wr2_mem, wr1_ctrl, wr2_ctrl;
    logic             coll;

    assign wr1_mem  = bus.enw1 && (region1 == REGION_MEM);
    assign wr2_mem  = bus.enw2 && (region2 == REGION_MEM);
    assign wr1_ctrl = bus.enw1 && (region1 == REGION_CTRL);
    assign wr2_ctrl = bus.enw2 && (region2 == REGION_CTRL);

    // Port 1 is applied after port 2 so its strobed bytes win on a shared word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr2_mem && bus.wstrb2[b]) mem[midx2][b*8 +: 8] <= bus.wdata2[b*8 +: 8];
            if (wr1_mem && bus.wstrb1[b]) mem[midx1][b*8 +: 8] <= bus.wdata1[b*8 +: 8];
        end
    end

    always_comb begin
        for (int k = 0; k < NCTRL; k++) begin
            ctrl_d[k] = ctrl_q[k];
            if (wr2_ctrl && (cidx2 == CIDX_W'(k))) ctrl_d[k] = merge_w(ctrl_d[k], bus.wdata2, bus.wstrb2);
            if (wr1_ctrl && (cidx1 == CIDX_W'(k))) ctrl_d[k] = merge_w(ctrl_d[k], bus.wdata1, bus.wstrb1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < NCTRL; k++) ctrl_q[k] <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    for (genvar k = 0; k < NCTRL; k++) begin : g_ctrl_out
        assign bus.ctrl_out[k*WIDTH +: WIDTH] = ctrl_q[k];
    end

    // Read muxes sample pre-edge state, which gives read-first ordering.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (region1 == REGION_MEM)       rd1 = mem[midx1];
        else if (region1 == REGION_CTRL) rd1 = ctrl_q[cidx1];
        if (region2 == REGION_MEM)       rd2 = mem[midx2];
        else if (region2 == REGION_CTRL) rd2 = ctrl_q[cidx2];
    end

    always_comb begin
        coll = 1'b0;
        if (bus.enw1 && bus.enw2 && ((bus.wstrb1 & bus.wstrb2) != '0)) begin
            coll = (wr1_mem && wr2_mem && (midx1 == midx2)) ||
                   (wr1_ctrl && wr2_ctrl && (cidx1 == cidx2));
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.rdata1    <= '0;
            bus.rdata2    <= '0;
            bus.rvalid1   <= 1'b0;
            bus.rvalid2   <= 1'b0;
            bus.err1      <= 1'b0;
            bus.err2      <= 1'b0;
            bus.collision <= 1'b0;
        end else begin
            if (bus.enr1) bus.rdata1 <= rd1;
            if (bus.enr2) bus.rdata2 <= rd2;
            bus.rvalid1   <= bus.enr1;
            bus.rvalid2   <= bus.enr2;
            bus.err1      <= (bus.enr1 || bus.enw1) && (region1 == REGION_NONE);
            bus.err2      <= (bus.enr2 || bus.enw2) && (region2 == REGION_NONE);
            bus.collision <= coll;
        end
    end

endmodule

// File: tb/tb_dualport_sram.sv
// tb/tb_dualport_sram.sv - directed and randomized bench for dualport_sram against a word-level model
module tb_dualport_sram;

    localparam longint BASE  = 206800;
    localparam longint DEPTH = 1200;
    localparam longint CBASE = 411698;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    dualport_sram_if #(.WIDTH(32), .NCTRL(2)) bus ();

    dualport_sram #(
        .WIDTH(32), .DEPTH(1200), .BASE(206800), .CTRL_BASE(411698), .NCTRL(2)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    logic [31:0] ref_mem  [1200];
    logic [31:0] ref_ctrl [2];
    logic [31:0] ref_rd1, ref_rd2;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = memory word, 1 = control register, 2 = unmapped
    function automatic int kind(input logic [31:0] a);
        longint u;
        u = {32'b0, a};
        if (u >= BASE && u < BASE + DEPTH) return 0;
        if (u >= CBASE && u < CBASE + 2) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] peek(input logic [31:0] a);
        longint u;
        u = {32'b0, a};
        case (kind(a))
            0:       return ref_mem[int'(u - BASE)];
            1:       return ref_ctrl[int'(u - CBASE)];
            default: return 32'h0;
        endcase
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        longint      u;
        u = {32'b0, a};
        w = peek(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        if (kind(a) == 0) ref_mem[int'(u - BASE)] = w;
        else if (kind(a) == 1) ref_ctrl[int'(u - CBASE)] = w;
    endtask

    // Called with the clock low; drives one edge's worth of requests and checks the results.
    task automatic cycle(
        input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
        input bit r2, input bit w2, input logic [31:0] a2, input logic [31:0] d2, input logic [3:0] s2
    );
        bit e_err1, e_err2, e_col;
        bus.enr1 = r1; bus.enw1 = w1; bus.address1 = a1; bus.wdata1 = d1; bus.wstrb1 = s1;
        bus.enr2 = r2; bus.enw2 = w2; bus.address2 = a2; bus.wdata2 = d2; bus.wstrb2 = s2;
        if (r1) ref_rd1 = peek(a1);
        if (r2) ref_rd2 = peek(a2);
        e_err1 = (r1 || w1) && (kind(a1) == 2);
        e_err2 = (r2 || w2) && (kind(a2) == 2);
        e_col  = w1 && w2 && (a1 == a2) && (kind(a1) != 2) && ((s1 & s2) != 4'h0);
        if (w2) poke(a2, d2, s2);
        if (w1) poke(a1, d1, s1);
        @(posedge clk);
        @(negedge clk);
        check("rvalid1", bus.rvalid1, r1);
        check("rvalid2", bus.rvalid2, r2);
        check("rdata1", bus.rdata1, ref_rd1);
        check("rdata2", bus.rdata2, ref_rd2);
        check("err1", bus.err1, e_err1);
        check("err2", bus.err2, e_err2);
        check("collision", bus.collision, e_col);
        check("ctrl_out", bus.ctrl_out, {ref_ctrl[1], ref_ctrl[0]});
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    // Asserts reset with a read still requested on port 1, then releases it.
    task automatic apply_reset();
        bus.enr1 = 1'b1; bus.address1 = 32'(CBASE);
        bus.enw1 = 1'b0; bus.enr2 = 1'b0; bus.enw2 = 1'b0;
        nrst = 1'b0;
        ref_ctrl[0] = 32'h0; ref_ctrl[1] = 32'h0; ref_rd1 = 32'h0; ref_rd2 = 32'h0;
        #1;
        check("rst_async_ctrl_out", bus.ctrl_out, 64'h0);
        check("rst_async_rvalid1", bus.rvalid1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_rvalid1", bus.rvalid1, 1'b0);
        check("rst_rdata1", bus.rdata1, 32'h0);
        check("rst_err1", bus.err1, 1'b0);
        check("rst_collision", bus.collision, 1'b0);
        check("rst_ctrl_out", bus.ctrl_out, 64'h0);
        bus.enr1 = 1'b0;
        nrst = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 32'(BASE + longint'($urandom_range(0, 1199)));
            6, 7:             return 32'(CBASE + longint'($urandom_range(0, 1)));
            8: begin
                case ($urandom_range(0, 3))
                    0:       return 32'(BASE - 1);
                    1:       return 32'(BASE + DEPTH);
                    2:       return 32'(CBASE - 1);
                    default: return 32'(CBASE + 2);
                endcase
            end
            default:          return $urandom;
        endcase
    endfunction

    task automatic random_cycles(input int n);
        logic [31:0] a1, a2;
        for (int i = 0; i < n; i++) begin
            a1 = rand_addr();
            a2 = ($urandom_range(0, 3) == 0) ? a1 : rand_addr();
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a2, $urandom, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        logic [31:0] old_word;
        bus.enr1 = 0; bus.enw1 = 0; bus.address1 = 0; bus.wdata1 = 0; bus.wstrb1 = 0;
        bus.enr2 = 0; bus.enw2 = 0; bus.address2 = 0; bus.wdata2 = 0; bus.wstrb2 = 0;
        ref_ctrl[0] = 0; ref_ctrl[1] = 0; ref_rd1 = 0; ref_rd2 = 0;

        @(negedge clk);
        check("reset_rdata1", bus.rdata1, 32'h0);
        check("reset_rvalid2", bus.rvalid2, 1'b0);
        check("reset_err1", bus.err1, 1'b0);
        check("reset_collision", bus.collision, 1'b0);
        check("reset_ctrl_out", bus.ctrl_out, 64'h0);
        nrst = 1'b1;

        cycle(1, 0, 32'(CBASE), 0, 0, 0, 0, 0, 0, 0);
        check("ctrl0_read_zero", bus.rdata1, 32'h0);
        check("ctrl0_read_valid", bus.rvalid1, 1'b1);

        for (int i = 0; i < 600; i++) begin
            cycle(0, 1, 32'(BASE + 2 * i), $urandom, 4'hF, 0, 1, 32'(BASE + 2 * i + 1), $urandom, 4'hF);
        end

        cycle(0, 1, 32'(CBASE), 32'hCAFE0001, 4'hF, 0, 0, 0, 0, 0);
        apply_reset();
        cycle(1, 0, 32'(CBASE), 0, 0, 0, 0, 0, 0, 0);
        check("post_reset_ctrl_read", bus.rdata1, 32'h0);

        cycle(0, 1, 32'd206800, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'd206800, 32'h00001100, 4'h2, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'd206800, 0, 0);
        check("strobe_merge_p2", bus.rdata2, 32'hDEAD11EF);

        cycle(0, 1, 32'd206801, 32'h0, 4'hF, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'd206801, 32'hAAAAAAAA, 4'h3, 0, 1, 32'd206801, 32'h55555555, 4'h6);
        check("collision_overlap", bus.collision, 1'b1);
        cycle(1, 0, 32'd206801, 0, 0, 0, 0, 0, 0, 0);
        check("collision_word", bus.rdata1, 32'h0055AAAA);
        check("collision_one_cycle", bus.collision, 1'b0);
        cycle(0, 1, 32'd206801, 32'hAAAAAAAA, 4'h3, 0, 1, 32'd206801, 32'h55555555, 4'hC);
        check("collision_disjoint", bus.collision, 1'b0);
        cycle(1, 0, 32'd206801, 0, 0, 0, 0, 0, 0, 0);
        check("disjoint_word", bus.rdata1, 32'h5555AAAA);

        cycle(1, 0, 32'd206799, 0, 0, 0, 0, 0, 0, 0);
        check("below_base_err", bus.err1, 1'b1);
        cycle(1, 0, 32'd208000, 0, 0, 0, 0, 0, 0, 0);
        check("above_top_rdata", bus.rdata1, 32'h0);
        cycle(1, 0, 32'd0, 0, 0, 0, 0, 0, 0, 0);
        check("addr_zero_err", bus.err1, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 1, 32'd208000, 32'hFFFFFFFF, 4'hF);
        check("write_none_err2", bus.err2, 1'b1);
        check("write_none_no_rvalid2", bus.rvalid2, 1'b0);
        cycle(1, 0, 32'd207999, 0, 0, 0, 0, 0, 0, 0);

        old_word = ref_mem[100];
        cycle(1, 0, 32'd206900, 0, 0, 0, 1, 32'd206900, 32'h12345678, 4'hF);
        check("read_first_old", bus.rdata1, {32'h0, old_word});
        cycle(1, 0, 32'd206900, 0, 0, 0, 0, 0, 0, 0);
        check("read_after_write", bus.rdata1, 32'h12345678);

        cycle(0, 1, 32'(CBASE), 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'd411699, 32'h1, 4'hF, 0, 0, 0, 0, 0);
        check("ctrl1_value", bus.ctrl_out[63:32], 32'h1);
        check("ctrl0_unchanged", bus.ctrl_out[31:0], 32'hA5A5A5A5);
        cycle(0, 1, 32'd411699, 32'hFFFFFFFF, 4'h1, 0, 1, 32'd411699, 32'h22222222, 4'h3);
        check("ctrl_collision", bus.collision, 1'b1);
        apply_reset();

        random_cycles(1500);
        apply_reset();
        idle();
        random_cycles(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dualport_sram.md
Name: dualport_sram

Overview:
- Single-clock, dual-port, word-addressed SRAM with a memory-mapped control-register bank; parametrised successor of the two-clock RAM in the SoC.
- Sits on the CPU data bus (port 1) and the JPEG accelerator/DMA bus (port 2).
- Adds the following:
  - byte strobes
  - registered reads with a valid flag
  - bounds-checked decode with an error flag
  - a deterministic collision policy
  - a resettable control bank exported to the system

Parameters:
- WIDTH, 32: data and address width in bits; must be a multiple of 8.
- DEPTH, 1200: number of memory words.
- BASE, 206800: word address of memory[0].
- CTRL_BASE, 411698: word address of ctrl[0].
- NCTRL, 2: number of control registers (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- address1, address2  in  WIDTH  word address for port 1 and port 2 (increments by 1 per word).
- wdata1, wdata2  in  WIDTH  write data.
- wstrb1, wstrb2  in  WIDTH/8  byte write strobes; bit i covers bits 8i+7:8i.
- enw1, enw2  in  1  write enable.
- enr1, enr2  in  1  read enable.
- rdata1, rdata2  out  WIDTH  registered read data.
- rvalid1, rvalid2  out  1  read data valid, one-cycle pulse.
- err1, err2  out  1  unmapped-access pulse, one cycle.
- collision  out  1  same-address dual-write pulse, one cycle.
- ctrl_out  out  NCTRL*WIDTH  control bank; ctrl[k] occupies bits k*WIDTH+WIDTH-1 : k*WIDTH.

Behaviour:
- Reset, with nrst low, asynchronously sets all of the following to 0:
  - rdata1 and rdata2
  - rvalid1 and rvalid2
  - err1 and err2
  - collision
  - all ctrl registers
- Memory array contents are not reset.
- Decode for each port is unsigned and must never wrap:
  - MEM when BASE <= addr < BASE+DEPTH; index = addr-BASE.
  - CTRL when CTRL_BASE <= addr < CTRL_BASE+NCTRL.
  - Otherwise NONE.
  - Addresses below BASE are NONE; an underflow of addr-BASE must never alias into memory.
- Write: at a rising edge with enwN=1, each byte whose wstrbN bit is set is written in the decoded MEM word or CTRL register. Unstrobed bytes are unchanged. wstrbN=0 with enwN=1 is a legal no-op.
- Read:
  - At a rising edge with enrN=1, rdataN is loaded and rvalidN is 1 on the following cycle. Latency is exactly 1.
  - When enrN=0, rvalidN is 0 and rdataN holds its last value.
  - Read of NONE: rdataN=0 and errN=1 in the same cycle as rvalidN.
- Write to NONE: no state change; errN=1 on the next cycle; rvalidN is unaffected.
- Read and write, same or opposite port, same word, same edge: read-first. The read returns the pre-write value; the new value is visible from the next read.
- Both ports write the same MEM word or CTRL register on the same edge:
  - Bytes strobed by port 1 take wdata1.
  - Bytes strobed only by port 2 take wdata2.
  - collision=1 next cycle, only if the strobes overlap in at least one byte.
- Both ports access the same address with enr only: no conflict; both read the same data.
- enrN and enwN both set on the same port: both actions occur, read-first.
- errN from a read and errN from a write in the same cycle on the same port: OR'd into a single pulse.
- ctrl_out is driven directly from the ctrl registers and updates the cycle after the write.
- Reset asserted mid-operation: pending rvalid, err and collision pulses are discarded, ctrl is cleared, and memory retains its contents.

Decomposition:
- Package dualport_sram_pkg holds:
  - region_t enum: REGION_MEM, REGION_CTRL, REGION_NONE.
  - Default constants SRAM_BASE=206800, SRAM_DEPTH=1200, CTRL_BASE=411698.
  - Function strb_merge(old, new, strb).
- One sub-module, sram_addr_decode: combinational, parametrised like the top, instantiated once per port. It outputs the region and the index.
- Top level contains the array, the ctrl bank, the collision logic and the output registers.

Test Plan:
- Reset with nrst=0 mid-read → next edge: rvalid1=0, ctrl_out=0. Release nrst, then read 411698 → rdata1=0, rvalid1=1 one cycle later.
- Port1 writes 206800 with wdata 0xDEADBEEF, wstrb 4'hF; then wstrb 4'h2 with wdata 0x00001100 → port2 read of 206800 returns 0xDEAD11EF with latency 1.
- Same edge: port1 writes 0xAAAAAAAA with wstrb 4'h3 and port2 writes 0x55555555 with wstrb 4'h6, both to 206801 → word = 0x0055AAAA, collision=1 for one cycle. Repeat with disjoint strobes (4'h3 and 4'hC) → collision stays 0.
- Port1 reads 206799, 208000 and 0 → rdata1=0 and err1=1 on each rvalid1. Port2 writes 208000 → err2=1 and no memory change; a read of 207999 is unchanged.
- Port2 writes 0x12345678 to 206900 while port1 reads 206900 on the same edge → rdata1 = old value. Port1 reads again the next cycle → 0x12345678.
- Port1 writes 411699 with 0x1 → ctrl_out[63:32]=1 the next cycle and ctrl_out[31:0] unchanged. Assert nrst → ctrl_out=0 asynchronously.
